// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline control blocks.
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W         = 5;
  localparam logic [4:0]  REG_ZERO           = 5'd0;
  localparam int unsigned MD_LATENCY_DEFAULT = 32;
  localparam int unsigned MD_CNT_W_DEFAULT   = 8;
  localparam int unsigned PERF_W             = 32;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy tracker for the iterative mult/div unit: loads LATENCY on issue,
// counts down, and reports busy while the unit is working.
module md_busy_counter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNT_W   = MD_CNT_W_DEFAULT,
  parameter int unsigned LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  hz_state_t        state;
  logic [CNT_W-1:0] md_cnt;

  // Busy spans exactly LATENCY cycles after the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (load) begin
            md_cnt <= CNT_W'(LATENCY);
            state  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (md_cnt <= CNT_W'(1)) begin
            md_cnt <= '0;
            state  <= RUN;
          end else begin
            md_cnt <= md_cnt - CNT_W'(1);
          end
        end
        default: begin
          md_cnt <= '0;
          state  <= RUN;
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, branch flushes and mult/div
// occupancy interlocks. Optional stall counter enabled by HAZARD_PERF_EN.
module id_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
  parameter int unsigned MD_LATENCY = mips_pipe_pkg::MD_LATENCY_DEFAULT,
  parameter int unsigned MD_CNT_W   = mips_pipe_pkg::MD_CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_md,
  input  logic                  id_reads_hilo,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  md_issue,
  output logic                  md_busy,
  output logic [31:0]           perf_stall_cnt
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(mips_pipe_pkg::REG_ZERO);

  logic lu_haz;
  logic md_haz;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign lu_haz = ex_mem_read & id_valid & (ex_rt != ZERO_REG) &
                  ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign md_haz = id_valid & (id_is_md | id_reads_hilo) & md_busy;

  // Priority: reset, taken branch, load-use, mult/div interlock, normal.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_issue    = 1'b0;
    if (rst) begin
      md_issue = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_haz || md_haz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      md_issue = id_valid & id_is_md & ~md_busy;
    end
  end

  md_busy_counter #(
    .CNT_W   (MD_CNT_W),
    .LATENCY (MD_LATENCY)
  ) u_md_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .load (md_issue),
    .busy (md_busy)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (!pc_write && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl with MD_LATENCY=4; perf expectations
// follow HAZARD_PERF_EN.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy;
  logic [31:0] perf_stall_cnt;

  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [31:0] perf;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_perf = 32'd0;

  id_hazard_ctrl #(
    .REG_ADDR_W (5),
    .MD_LATENCY (4),
    .MD_CNT_W   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_md        (id_is_md),
    .id_reads_hilo   (id_reads_hilo),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_issue        (md_issue),
    .md_busy         (md_busy),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected vectors: {pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy}
  localparam logic [5:0] E_NORM  = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b000100;
  localparam logic [5:0] E_MDSTL = 6'b000101;
  localparam logic [5:0] E_ISSUE = 6'b110010;
  localparam logic [5:0] E_BR    = 6'b111100;
  localparam logic [5:0] E_BRBSY = 6'b111101;
  localparam logic [5:0] E_BUSY  = 6'b110001;

  task automatic clr();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_md = 0; id_reads_hilo = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
  endtask

  task automatic tick(input string nm, input logic [5:0] ctl);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.perf = exp_perf;
    q.push_back(e);
`ifdef HAZARD_PERF_EN
    if (!ctl[5]) exp_perf = exp_perf + 32'd1;
`endif
    @(posedge clk); #1;
  endtask

  task automatic rst_tick();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_perf = 32'd0;
  endtask

  // Monitor: compare one expectation per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy} !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl actual=%b required=%b", e.nm,
                   {pc_write, ifid_write, ifid_flush, idex_bubble, md_issue, md_busy}, e.ctl);
        end
        checks++;
        if (perf_stall_cnt !== e.perf) begin
          errors++;
          $display("FAIL %s perf actual=%0d required=%0d", e.nm, perf_stall_cnt, e.perf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    tick("reset_idle", E_NORM);

    id_valid = 1; id_uses_rs = 1; id_rs = 8; ex_mem_read = 1; ex_rt = 8;
    tick("lu_rs", E_LU);
    ex_mem_read = 0;
    tick("lu_release", E_NORM);

    id_rs = 3; id_uses_rt = 1; id_rt = 9; ex_mem_read = 1; ex_rt = 9;
    tick("lu_rt", E_LU);
    id_uses_rt = 0;
    tick("rt_unused", E_NORM);

    clr(); id_valid = 1; id_uses_rs = 1; id_rs = 0; ex_mem_read = 1; ex_rt = 0;
    tick("zero_reg", E_NORM);

    clr(); id_uses_rs = 1; id_rs = 8; ex_mem_read = 1; ex_rt = 8;
    tick("id_invalid", E_NORM);

    clr();
    rst_tick();

    id_valid = 1; id_uses_rs = 1; id_rs = 8; ex_mem_read = 1; ex_rt = 8;
    tick("perf_lu", E_LU);
    clr(); id_valid = 1; id_is_md = 1;
    tick("mult_issue", E_ISSUE);
    clr(); id_valid = 1; id_reads_hilo = 1;
    for (int i = 0; i < 4; i++) tick($sformatf("mfhi_stall%0d", i + 1), E_MDSTL);
    tick("mfhi_release", E_NORM);

    clr(); id_valid = 1; id_is_md = 1; id_uses_rs = 1; id_rs = 8;
    ex_mem_read = 1; ex_rt = 8; ex_branch_taken = 1;
    tick("br_lu_md", E_BR);
    clr();
    tick("br_no_load", E_NORM);

    id_valid = 1; id_is_md = 1;
    tick("mult_issue2", E_ISSUE);
    ex_branch_taken = 1;
    tick("br_in_busy", E_BRBSY);
    ex_branch_taken = 0;
    for (int i = 0; i < 3; i++) tick($sformatf("mult_wait%0d", i + 2), E_MDSTL);
    tick("mult_issue3", E_ISSUE);
    tick("b2b_stall", E_MDSTL);

    clr();
    rst_tick();
    id_valid = 1; id_is_md = 1;
    tick("post_rst_issue", E_ISSUE);
    clr();
    tick("post_rst_busy", E_BUSY);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending actual=%0d required=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
